shift_align_pipe: RTL and testbench
===================================

# shift_align_pipe

Parametrised, two-stage pipelined barrel shifter for the floating-point add/sub datapath. Right mode aligns the smaller operand's mantissa and returns guard, round and sticky bits for rounding. Left mode normalises a result mantissa and flags any lost non-zero bits. It sits between exponent compare and the mantissa adder (right mode) and after the adder (left mode), with valid/ready flow control and a tag carried alongside the data.

## Interface
- WIDTH, 24, mantissa width including hidden bit
- SHW, 8, shift-amount width
- SPLIT, 3, low amount bits applied in stage 2; high bits are applied in stage 1
- TAGW, 4, width of the pass-through tag
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts the beat this cycle
- in_data  in  WIDTH  operand
- in_amt  in  SHW  shift amount, unsigned
- in_left  in  1  0 = right/align, 1 = left/normalise
- in_tag  in  TAGW  opaque tag
- out_valid  out  1  result present
- out_ready  in  1  consumer takes the result
- out_data  out  WIDTH  shifted operand
- out_grs  out  3  {guard, round, sticky}; always 0 in left mode
- out_lost  out  1  left mode: a 1 was shifted out; always 0 in right mode
- out_tag  out  TAGW  in_tag of the same beat

## Operation
- Right mode:
  - Form E = {in_data, 2'b00} (WIDTH+2 bits) and shift E right logically by in_amt.
  - out_data = E[WIDTH+1:2], guard = E[1], round = E[0].
  - sticky = OR of all bits shifted below E[0].
  - If in_amt ≥ WIDTH+2: out_data = 0, guard = round = 0, sticky = |in_data.
- Left mode:
  - out_data = in_data << in_amt, truncated to WIDTH bits; zeros fill from the LSB.
  - out_lost = OR of the bits shifted out above the MSB.
  - If in_amt ≥ WIDTH: out_data = 0, out_lost = |in_data.
- Stage split:
  - Stage 1 shifts by in_amt with the low SPLIT bits cleared, saturating as above. It registers the partial result, the partial sticky/lost bit, the low SPLIT amount bits, the mode and the tag.
  - Stage 2 applies the low SPLIT bits and ORs the newly shifted-out bits into sticky/lost.
  - The final result must be bit-identical to the single-shift definition above for every amount from 0 to 2^SHW−1.
- Amount 0: out_data = in_data, out_grs = 0, out_lost = 0.
- Tag, mode and data of a beat always travel together; beats leave in acceptance order.

## Timing
- Latency: a beat accepted in cycle N (in_valid & in_ready) presents out_valid=1 in cycle N+2 when the output is not stalled.
- Throughput: one beat per cycle while out_ready=1.
- Handshake rules:
  - Stage 2 loads when it is empty or out_ready=1.
  - Stage 1 loads when it is empty or stage 2 loads.
  - in_ready = !rst & (stage 1 empty or stage 2 loads). This is a combinational path from out_ready, which is permitted.
- While out_valid=1 & out_ready=0, out_data, out_grs, out_lost and out_tag hold stable. in_ready falls only once both stages are full.
- in_valid may be asserted or withdrawn in any cycle. Input fields are sampled only on an accept.
- Reset:
  - While rst=1: both stage valids clear; out_valid = 0, out_data = 0, out_grs = 0, out_lost = 0, out_tag = 0, in_ready = 0.
  - Reset mid-operation discards in-flight beats; no stale beat appears after reset.
  - in_ready = 1 in the first cycle with rst=0.
- Simultaneous accept and output consume in the same cycle: both happen; occupancy is unchanged.

## Test plan
- Right, in_data=0x800001, amt=1 → out_data=0x400000, grs=3'b100. out_valid exactly 2 cycles after accept; out_tag matches.
- Right, in_data=0x00000F, amt=3 → out_data=0x000001, grs=3'b111. Same in_data with amt=30 → out_data=0, grs=3'b001. in_data=0, amt=255 → all 0.
- Left, in_data=0xF00001, amt=4 → out_data=0x000010, out_lost=1. in_data=0x000001, amt=23 → out_data=0x800000, out_lost=0.
- Backpressure:
  - Stimulus: hold out_ready=0 and offer three back-to-back beats tagged 1, 2, 3.
  - Required: in_ready drops after 2 accepts and beat 1's output is held stable. When out_ready rises, tags 1, 2, 3 appear in order with no loss or duplication.
- Reset mid-flight: two beats in the pipe, assert rst for 1 cycle → out_valid=0 and all outputs 0 in the following cycle, no in-flight beat ever emerges, and in_ready=1 once rst=0.
- Random sweep: all amounts 0–255 in both modes with random data and random out_ready against a reference model → exact match on out_data, out_grs and out_lost.

Source files
------------

// File: rtl/shift_align_pipe_if.sv
// Handshake bundle for the shift/align pipe.
// master drives operands and out_ready; slave is the shifter.
interface shift_align_pipe_if #(
    parameter int WIDTH = 24,
    parameter int SHW   = 8,
    parameter int TAGW  = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;
    logic             in_left;
    logic [TAGW-1:0]  in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       out_grs;
    logic             out_lost;
    logic [TAGW-1:0]  out_tag;

    modport master (
        output in_valid, in_data, in_amt, in_left, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_grs, out_lost, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_left, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_grs, out_lost, out_tag
    );
endinterface

// File: rtl/shift_align_pipe.sv
// Two-stage barrel shifter: right mode aligns with guard/round/sticky,
// left mode normalises and flags lost ones. Coarse shift first, fine second.
module shift_align_pipe #(
    parameter int WIDTH = 24,
    parameter int SHW   = 8,
    parameter int SPLIT = 3,
    parameter int TAGW  = 4
) (
    input logic              clk,
    input logic              rst,
    shift_align_pipe_if.slave bus
);
    localparam int EW = WIDTH + 2;

    typedef struct packed {
        logic [EW-1:0]    p;
        logic             flag;
        logic [SPLIT-1:0] lo;
        logic             left;
        logic [TAGW-1:0]  tag;
    } s1_t;

    logic             s1_v, s2_v;
    s1_t              s1_q, s1_d;
    logic [WIDTH-1:0] s2_data, d2;
    logic [2:0]       s2_grs, grs2;
    logic             s2_lost, lost2;
    logic [TAGW-1:0]  s2_tag;
    logic             ld1, ld2, acc;
    logic [SHW-1:0]   amt_hi;
    logic [2*EW-1:0]  rw1, rw2;
    logic [2*WIDTH-1:0] lw1, lw2;

    assign ld2 = !s2_v || bus.out_ready;
    assign ld1 = !s1_v || ld2;
    assign bus.in_ready = !rst && ld1;
    assign acc = bus.in_valid && bus.in_ready;

    // Stage 1: coarse shift by the amount with its low SPLIT bits cleared
    assign amt_hi = {bus.in_amt[SHW-1:SPLIT], {SPLIT{1'b0}}};
    assign rw1 = {bus.in_data, 2'b00, {EW{1'b0}}} >> amt_hi;
    assign lw1 = {{WIDTH{1'b0}}, bus.in_data} << amt_hi;

    always_comb begin
        s1_d      = '0;
        s1_d.lo   = bus.in_amt[SPLIT-1:0];
        s1_d.left = bus.in_left;
        s1_d.tag  = bus.in_tag;
        if (bus.in_left) begin
            if (32'(amt_hi) >= WIDTH) begin
                s1_d.flag = |bus.in_data;
            end else begin
                s1_d.p    = {2'b00, lw1[WIDTH-1:0]};
                s1_d.flag = |lw1[2*WIDTH-1:WIDTH];
            end
        end else begin
            if (32'(amt_hi) >= EW) begin
                s1_d.flag = |bus.in_data;
            end else begin
                s1_d.p    = rw1[2*EW-1:EW];
                s1_d.flag = |rw1[EW-1:0];
            end
        end
    end

    // Stage 2: fine shift, folding newly dropped bits into sticky/lost
    assign rw2 = {s1_q.p, {EW{1'b0}}} >> s1_q.lo;
    assign lw2 = {{WIDTH{1'b0}}, s1_q.p[WIDTH-1:0]} << s1_q.lo;

    always_comb begin
        d2    = '0;
        grs2  = '0;
        lost2 = 1'b0;
        if (s1_q.left) begin
            d2    = lw2[WIDTH-1:0];
            lost2 = s1_q.flag || (|lw2[2*WIDTH-1:WIDTH]);
        end else begin
            d2   = rw2[2*EW-1:EW+2];
            grs2 = {rw2[EW+1], rw2[EW], s1_q.flag || (|rw2[EW-1:0])};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_q    <= '0;
            s2_v    <= 1'b0;
            s2_data <= '0;
            s2_grs  <= '0;
            s2_lost <= 1'b0;
            s2_tag  <= '0;
        end else begin
            if (ld1) begin
                s1_v <= acc;
                if (acc) s1_q <= s1_d;
            end
            if (ld2) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_data <= d2;
                    s2_grs  <= grs2;
                    s2_lost <= lost2;
                    s2_tag  <= s1_q.tag;
                end
            end
        end
    end

    // Outputs read as zero for the whole reset cycle, not just after it
    assign bus.out_valid = s2_v && !rst;
    assign bus.out_data  = rst ? '0 : s2_data;
    assign bus.out_grs   = rst ? '0 : s2_grs;
    assign bus.out_lost  = !rst && s2_lost;
    assign bus.out_tag   = rst ? '0 : s2_tag;
endmodule

// File: tb/tb_shift_align_pipe.sv
// Bench for shift_align_pipe: directed cases, backpressure, reset,
// and a random sweep of every amount against a bit-level model.
module tb_shift_align_pipe;
    localparam int W = 24;
    localparam int N = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    shift_align_pipe_if #(.WIDTH(W), .SHW(8), .TAGW(4)) bus ();

    shift_align_pipe #(.WIDTH(W), .SHW(8), .SPLIT(3), .TAGW(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [W-1:0] d;
        logic [2:0]   g;
        logic         l;
        logic [3:0]   t;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] rd[N];
    logic [3:0]   got[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // Bit-by-bit definition of the shift, independent of the stage split
    function automatic exp_t model(logic [W-1:0] d, int amt, logic left, logic [3:0] t);
        exp_t         e;
        logic [W+1:0] ext, r;
        e.d = '0; e.g = '0; e.l = 1'b0; e.t = t;
        if (left) begin
            for (int i = 0; i < W; i++)
                if (i - amt >= 0) e.d[i] = d[i-amt];
            for (int j = 0; j < W; j++)
                if (j + amt >= W && d[j]) e.l = 1'b1;
        end else begin
            ext = {d, 2'b00};
            r = '0;
            for (int i = 0; i < W + 2; i++)
                if (i + amt <= W + 1) r[i] = ext[i+amt];
            for (int j = 0; j < W + 2; j++)
                if (j < amt && ext[j]) e.g[0] = 1'b1;
            e.d = r[W+1:2];
            e.g[2:1] = r[1:0];
        end
        return e;
    endfunction

    task automatic drive(logic v, logic [W-1:0] d, logic [7:0] a, logic l, logic [3:0] t);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_amt   = a;
        bus.in_left  = l;
        bus.in_tag   = t;
    endtask

    task automatic run_one(string nm, logic [W-1:0] d, logic [7:0] a, logic l,
                           logic [3:0] t, logic [W-1:0] ed, logic [2:0] eg, logic el);
        @(negedge clk);
        drive(1'b1, d, a, l, t);
        bus.out_ready = 1'b1;
        #1 chk({nm, "_rdy"}, 32'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1 chk({nm, "_early"}, 32'(bus.out_valid), 0);
        @(negedge clk);
        #1;
        chk({nm, "_lat"}, 32'(bus.out_valid), 1);
        chk({nm, "_data"}, 32'(bus.out_data), 32'(ed));
        chk({nm, "_grs"}, 32'(bus.out_grs), 32'(eg));
        chk({nm, "_lost"}, 32'(bus.out_lost), 32'(el));
        chk({nm, "_tag"}, 32'(bus.out_tag), 32'(t));
    endtask

    initial begin
        logic [W-1:0] held;
        int           seen, idx, cyc;
        exp_t         e, f;

        drive(1'b0, '0, '0, 1'b0, '0);
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_ready", 32'(bus.in_ready), 0);
        chk("rst_data", 32'(bus.out_data), 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_rel_ready", 32'(bus.in_ready), 1);

        run_one("r1", 24'h800001, 8'd1, 1'b0, 4'd5, 24'h400000, 3'b100, 1'b0);
        run_one("r3", 24'h00000F, 8'd3, 1'b0, 4'd6, 24'h000001, 3'b111, 1'b0);
        run_one("r30", 24'h00000F, 8'd30, 1'b0, 4'd7, 24'h000000, 3'b001, 1'b0);
        run_one("r255", 24'h000000, 8'd255, 1'b0, 4'd8, 24'h000000, 3'b000, 1'b0);
        run_one("l4", 24'hF00001, 8'd4, 1'b1, 4'd9, 24'h000010, 3'b000, 1'b1);
        run_one("l23", 24'h000001, 8'd23, 1'b1, 4'd10, 24'h800000, 3'b000, 1'b0);
        run_one("z0", 24'hABCDEF, 8'd0, 1'b0, 4'd11, 24'hABCDEF, 3'b000, 1'b0);

        // Backpressure: three beats against a stalled consumer
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(1'b1, 24'h000111, 8'd0, 1'b0, 4'd1);
        #1 chk("bp_acc1", 32'(bus.in_ready), 1);
        @(negedge clk);
        drive(1'b1, 24'h000222, 8'd0, 1'b0, 4'd2);
        #1 chk("bp_acc2", 32'(bus.in_ready), 1);
        @(negedge clk);
        drive(1'b1, 24'h000333, 8'd0, 1'b0, 4'd3);
        #1;
        chk("bp_full", 32'(bus.in_ready), 0);
        chk("bp_head", 32'(bus.out_tag), 1);
        held = bus.out_data;
        @(negedge clk);
        #1;
        chk("bp_hold", 32'(bus.out_data), 32'(held));
        chk("bp_hold_v", 32'(bus.out_valid), 1);
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_resume", 32'(bus.in_ready), 1);
        if (bus.out_valid) got.push_back(bus.out_tag);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            if (bus.out_valid) got.push_back(bus.out_tag);
        end
        chk("bp_count", 32'(got.size()), 3);
        for (int k = 0; k < got.size() && k < 3; k++)
            chk("bp_order", 32'(got[k]), 32'(k + 1));

        // Reset with two beats in flight
        @(negedge clk);
        drive(1'b1, 24'h123456, 8'd2, 1'b0, 4'd12);
        @(negedge clk);
        drive(1'b1, 24'h654321, 8'd1, 1'b1, 4'd13);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mr_valid_in_rst", 32'(bus.out_valid), 0);
        chk("mr_ready_in_rst", 32'(bus.in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mr_valid", 32'(bus.out_valid), 0);
        chk("mr_data", 32'(bus.out_data), 0);
        chk("mr_grs", 32'(bus.out_grs), 0);
        chk("mr_lost", 32'(bus.out_lost), 0);
        chk("mr_tag", 32'(bus.out_tag), 0);
        chk("mr_ready", 32'(bus.in_ready), 1);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        chk("mr_no_stale", 32'(seen), 0);

        // Random sweep: every amount in both modes, random flow control
        for (int i = 0; i < N; i++) rd[i] = W'($urandom);
        idx = 0;
        cyc = 0;
        while ((idx < N || sb.size() != 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            drive((idx < N) && ($urandom_range(0, 3) != 0), rd[idx % N],
                  8'(idx % 256), (idx >= 256), 4'(idx));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("sw_extra", 32'(bus.out_valid), 0);
                end else begin
                    f = sb.pop_front();
                    chk("sw_data", 32'(bus.out_data), 32'(f.d));
                    chk("sw_grs", 32'(bus.out_grs), 32'(f.g));
                    chk("sw_lost", 32'(bus.out_lost), 32'(f.l));
                    chk("sw_tag", 32'(bus.out_tag), 32'(f.t));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e = model(bus.in_data, int'(bus.in_amt), bus.in_left, bus.in_tag);
                sb.push_back(e);
                idx++;
            end
        end
        chk("sw_done", 32'(idx), N);
        chk("sw_drained", 32'(sb.size()), 0);

        @(negedge clk);
        bus.in_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
